mem_unit: RTL

//  Parametrised single-port data memory with a valid/ready request channel and a buffered read-response channel.

---
 rtl/mem_unit_pkg.sv | 22 ++
 rtl/resp_fifo.sv | 81 ++++++++
 rtl/mem_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mem_unit_pkg.sv
// mem_unit_pkg: shared types and defaults for the data memory unit.
//   state_t            - FSM encodings (ST_INIT clears the array, ST_RUN serves requests)
//   DEF_*              - default widths/depths shared with the register file and datapath
//   clog2_min1()       - index width helper that never returns zero
package mem_unit_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_RSP_DEPTH = 4;

    // Width of an index able to address n entries; at least 1 bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: synchronous FIFO carrying read responses.
//   clk, rst        clock, asynchronous active-high reset (empties the FIFO)
//   push, wdata     enqueue wdata
//   pop             dequeue the head entry
//   rdata           head entry (valid when !empty)
//   empty           no entries stored
// Push and pop in the same cycle are allowed whether the FIFO is full or empty.
module resp_fifo
    import mem_unit_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // When full, a simultaneous pop frees the head slot the push lands in.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = store[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr_q] <= wdata;
    end

    // The upstream credit scheme must never push into a full FIFO without a pop.
    always @(posedge clk) begin
        if (!rst && push) assert (!full || pop);
    end

endmodule

// File: rtl/mem_unit.sv
// mem_unit: single-port data memory with valid/ready requests and buffered read responses.
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake
//   req_write, req_addr          1 = write / 0 = read, word address
//   req_wdata, req_be            write data and byte enables (writes only)
//   rsp_valid/rsp_ready          response handshake
//   rsp_rdata, rsp_err           read data (0 on error), out-of-range flag
//   wr_err                       one-cycle pulse after an out-of-range write is dropped
//   init_done                    array clear after reset has completed
// After reset the array is cleared one word per cycle (DEPTH cycles) before requests are accepted.
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int RSP_DEPTH = DEF_RSP_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                wr_err,
    output logic                init_done
);

    localparam int          BE_W    = DATA_W / 8;
    localparam int          IDX_W   = clog2_min1(DEPTH);
    localparam int          CRD_W   = $clog2(RSP_DEPTH + 1);
    localparam int unsigned DEPTH_U = DEPTH;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    init_ptr_q, init_ptr_d;
    logic [CRD_W-1:0]    credit_q, credit_d;
    logic                stg_valid_q, stg_valid_d;
    logic                stg_err_q, stg_err_d;
    logic [DATA_W-1:0]   stg_rdata_q;
    logic                wr_err_q, wr_err_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [BE_W-1:0]     mem_wbe;

    logic                in_range;
    logic                accept, wr_acc, rd_acc, rsp_pop;
    logic [DATA_W:0]     fifo_wdata, fifo_rdata;
    logic                fifo_empty;

    assign in_range = (32'(req_addr) < DEPTH_U);
    assign accept   = req_valid && req_ready;
    assign wr_acc   = accept && req_write;
    assign rd_acc   = accept && !req_write;
    assign rsp_pop  = rsp_valid && rsp_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && init_ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
    end

    // ---------------- FSM: outputs ----------------
    // Credit covers the stage register plus FIFO, so the FIFO cannot overflow.
    always_comb begin
        init_done = (state_q == ST_RUN);
        req_ready = (state_q == ST_RUN) && (credit_q < CRD_W'(RSP_DEPTH));
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        init_ptr_d  = init_ptr_q;
        credit_d    = credit_q;
        stg_valid_d = rd_acc;
        stg_err_d   = rd_acc && !in_range;
        wr_err_d    = wr_acc && !in_range;
        if (state_q == ST_INIT) init_ptr_d = init_ptr_q + 1'b1;
        case ({rd_acc, rsp_pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_ptr_q  <= '0;
            credit_q    <= '0;
            stg_valid_q <= 1'b0;
            stg_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            init_ptr_q  <= init_ptr_d;
            credit_q    <= credit_d;
            stg_valid_q <= stg_valid_d;
            stg_err_q   <= stg_err_d;
            wr_err_q    <= wr_err_d;
        end
    end

    // ---------------- array write port ----------------
    // INIT owns the write port; in RUN only in-range accepted writes reach the array.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = req_addr[IDX_W-1:0];
        mem_wdata = req_wdata;
        mem_wbe   = req_be;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else begin
            mem_we    = wr_acc && in_range;
        end
    end

    // Array and its registered read; no reset so this maps onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (mem_we && mem_wbe[i]) mem[mem_waddr][i*8 +: 8] <= mem_wdata[i*8 +: 8];
        end
        if (rd_acc) stg_rdata_q <= mem[req_addr[IDX_W-1:0]];
    end

    // ---------------- response FIFO ----------------
    // Out-of-range reads may have fetched an aliased word; force their data to 0.
    assign fifo_wdata = {stg_err_q, (stg_err_q ? {DATA_W{1'b0}} : stg_rdata_q)};

    resp_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (RSP_DEPTH)
    ) u_resp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (stg_valid_q),
        .wdata (fifo_wdata),
        .pop   (rsp_pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty)
    );

    // Storage contents are undefined until written, so outputs are gated by empty.
    assign rsp_valid = !fifo_empty;
    assign rsp_rdata = fifo_empty ? '0 : fifo_rdata[DATA_W-1:0];
    assign rsp_err   = !fifo_empty && fifo_rdata[DATA_W];
    assign wr_err    = wr_err_q;

endmodule
